// File: rtl/switch_event_gen_pkg.sv
// Shared event codes and FSM state encoding for the switch event generator
// and the one-entry event buffer.
package switch_event_gen_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_LONG    = 2'd2;
    localparam logic [1:0] EVT_REPEAT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

endpackage

// File: rtl/switch_event_gen_event_buf_1.sv
// One-entry valid/ready holding register; a push into a full, stalled entry
// is dropped and raises a sticky overrun flag.
module event_buf_1 #(
    parameter int unsigned CODE_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [CODE_WIDTH-1:0] push_code,
    input  logic                  ready,
    input  logic                  clear_overrun,
    output logic                  valid,
    output logic [CODE_WIDTH-1:0] code,
    output logic                  overrun
);

    logic accept;
    logic drop;

    assign accept = valid && ready;
    assign drop   = push && valid && !ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            code  <= '0;
        end else if (push && (!valid || ready)) begin
            valid <= 1'b1;
            code  <= push_code;
        end else if (accept) begin
            valid <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/switch_event_gen.sv
// Turns the debounced switch level into PRESS/RELEASE/LONG/REPEAT events,
// presented through a one-entry valid/ready buffer.
module switch_event_gen
    import switch_event_gen_pkg::*;
#(
    parameter int unsigned c_LONG_LIMIT   = 25000000,
    parameter int unsigned c_REPEAT_LIMIT = 5000000,
    parameter int unsigned c_CNT_WIDTH    = 25
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_switch,
    output logic       o_event_valid,
    output logic [1:0] o_event_code,
    input  logic       i_event_ready,
    output logic       o_overrun,
    input  logic       i_clear_overrun,
    output logic [7:0] o_press_count
);

    localparam logic [c_CNT_WIDTH-1:0] LONG_TERM   = c_CNT_WIDTH'(c_LONG_LIMIT - 1);
    localparam logic [c_CNT_WIDTH-1:0] REPEAT_TERM = c_CNT_WIDTH'(c_REPEAT_LIMIT - 1);
    localparam logic [c_CNT_WIDTH-1:0] CNT_ONE     = c_CNT_WIDTH'(1);

    state_t                 state;
    state_t                 next_state;
    logic                   prev;
    logic [c_CNT_WIDTH-1:0] cnt;
    logic [c_CNT_WIDTH-1:0] next_cnt;
    logic                   gen;
    logic [1:0]             gen_code;
    logic                   rise;

    assign rise = i_switch && !prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            prev          <= 1'b0;
            cnt           <= '0;
            o_press_count <= '0;
        end else begin
            state <= next_state;
            prev  <= i_switch;
            cnt   <= next_cnt;
            if (gen && gen_code == EVT_PRESS) begin
                o_press_count <= o_press_count + 8'd1;
            end
        end
    end

    // The terminal test uses the pre-increment count, so LONG lands exactly
    // c_LONG_LIMIT cycles after PRESS; release is checked first and wins.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        gen        = 1'b0;
        gen_code   = EVT_PRESS;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    gen        = 1'b1;
                    gen_code   = EVT_PRESS;
                    next_cnt   = '0;
                    next_state = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!i_switch) begin
                    gen        = 1'b1;
                    gen_code   = EVT_RELEASE;
                    next_state = ST_IDLE;
                end else if (cnt == LONG_TERM) begin
                    gen        = 1'b1;
                    gen_code   = EVT_LONG;
                    next_cnt   = '0;
                    next_state = ST_REPEAT;
                end else begin
                    next_cnt = cnt + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (!i_switch) begin
                    gen        = 1'b1;
                    gen_code   = EVT_RELEASE;
                    next_state = ST_IDLE;
                end else if (cnt == REPEAT_TERM) begin
                    gen      = 1'b1;
                    gen_code = EVT_REPEAT;
                    next_cnt = '0;
                end else begin
                    next_cnt = cnt + CNT_ONE;
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    event_buf_1 #(
        .CODE_WIDTH(2)
    ) u_event_buf (
        .clk           (i_clk),
        .rst           (i_rst),
        .push          (gen),
        .push_code     (gen_code),
        .ready         (i_event_ready),
        .clear_overrun (i_clear_overrun),
        .valid         (o_event_valid),
        .code          (o_event_code),
        .overrun       (o_overrun)
    );

endmodule

// File: tb/tb_switch_event_gen.sv
// Directed bench for switch_event_gen with short limits (LONG=10, REPEAT=4).
module tb_switch_event_gen;
    import switch_event_gen_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw = 1'b0;
    logic       ready = 1'b1;
    logic       clr = 1'b0;
    logic       valid;
    logic [1:0] code;
    logic       overrun;
    logic [7:0] press_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [7:0]  exp_presses = 8'd0;

    switch_event_gen #(
        .c_LONG_LIMIT   (10),
        .c_REPEAT_LIMIT (4),
        .c_CNT_WIDTH    (5)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_switch        (sw),
        .o_event_valid   (valid),
        .o_event_code    (code),
        .i_event_ready   (ready),
        .o_overrun       (overrun),
        .i_clear_overrun (clr),
        .o_press_count   (press_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed {valid, code} with code masked while idle.
    function automatic logic [2:0] ev();
        return {valid, valid ? code : 2'b00};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({valid, code, overrun, press_count} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b c=%0d ovr=%b pc=%0d want all 0", valid, code, overrun, press_count);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (ev() !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_idle: got %b want 000", ev());
        end
    endtask

    task automatic test_short_press();
        ready = 1'b1;
        sw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            logic [2:0] exp;
            if (k == 6) sw = 1'b0;
            tick();
            exp = (k == 1) ? {1'b1, EVT_PRESS} : (k == 6) ? {1'b1, EVT_RELEASE} : 3'b000;
            vectors++;
            if (ev() !== exp) begin
                miscompares++;
                $display("FAIL short_press_t%0d: got %b want %b", k, ev(), exp);
            end
        end
        exp_presses = exp_presses + 8'd1;
        vectors++;
        if (press_count !== exp_presses) begin
            miscompares++;
            $display("FAIL short_press_count: got %0d want %0d", press_count, exp_presses);
        end
    endtask

    task automatic test_long_hold();
        ready = 1'b1;
        sw = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            logic [2:0] exp;
            if (k == 21) sw = 1'b0;
            tick();
            case (k)
                1:       exp = {1'b1, EVT_PRESS};
                11:      exp = {1'b1, EVT_LONG};
                15, 19:  exp = {1'b1, EVT_REPEAT};
                21:      exp = {1'b1, EVT_RELEASE};
                default: exp = 3'b000;
            endcase
            vectors++;
            if (ev() !== exp) begin
                miscompares++;
                $display("FAIL long_hold_t%0d: got %b want %b", k, ev(), exp);
            end
        end
        exp_presses = exp_presses + 8'd1;
    endtask

    task automatic test_boundary();
        ready = 1'b1;
        sw = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            logic [2:0] exp;
            if (k == 11) sw = 1'b0;
            tick();
            exp = (k == 1) ? {1'b1, EVT_PRESS} : (k == 11) ? {1'b1, EVT_RELEASE} : 3'b000;
            vectors++;
            if (ev() !== exp) begin
                miscompares++;
                $display("FAIL boundary_t%0d: got %b want %b", k, ev(), exp);
            end
        end
        exp_presses = exp_presses + 8'd1;
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        sw = 1'b1;
        tick();
        tick();
        tick();
        vectors++;
        if ({ev(), overrun} !== {1'b1, EVT_PRESS, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_held: got ev=%b ovr=%b want ev=100 ovr=0", ev(), overrun);
        end
        sw = 1'b0;
        tick();
        vectors++;
        if ({ev(), overrun} !== {1'b1, EVT_PRESS, 1'b1}) begin
            miscompares++;
            $display("FAIL bp_drop: got ev=%b ovr=%b want ev=100 ovr=1", ev(), overrun);
        end
        ready = 1'b1;
        tick();
        vectors++;
        if ({ev(), overrun} !== 4'b0001) begin
            miscompares++;
            $display("FAIL bp_consume: got ev=%b ovr=%b want ev=000 ovr=1", ev(), overrun);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_clear: got %b want 0", overrun);
        end
        // drop and clear in the same cycle: the drop must win
        ready = 1'b0;
        sw = 1'b1;
        tick();
        sw = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vectors++;
        if ({ev(), overrun} !== {1'b1, EVT_PRESS, 1'b1}) begin
            miscompares++;
            $display("FAIL bp_drop_beats_clear: got ev=%b ovr=%b want ev=100 ovr=1", ev(), overrun);
        end
        ready = 1'b1;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        vectors++;
        if ({ev(), overrun} !== 4'b0000) begin
            miscompares++;
            $display("FAIL bp_final: got ev=%b ovr=%b want ev=000 ovr=0", ev(), overrun);
        end
        exp_presses = exp_presses + 8'd2;
        vectors++;
        if (press_count !== exp_presses) begin
            miscompares++;
            $display("FAIL bp_press_count: got %0d want %0d", press_count, exp_presses);
        end
    endtask

    task automatic test_back_to_back();
        ready = 1'b0;
        sw = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            logic [2:0] exp;
            if (k == 11) ready = 1'b1;
            if (k == 13) sw = 1'b0;
            tick();
            case (k)
                11:      exp = {1'b1, EVT_LONG};
                12, 14:  exp = 3'b000;
                13:      exp = {1'b1, EVT_RELEASE};
                default: exp = {1'b1, EVT_PRESS};
            endcase
            vectors++;
            if (ev() !== exp) begin
                miscompares++;
                $display("FAIL b2b_t%0d: got %b want %b", k, ev(), exp);
            end
        end
        exp_presses = exp_presses + 8'd1;
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_no_overrun: got %b want 0", overrun);
        end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        sw = 1'b1;
        for (int k = 1; k <= 13; k++) tick();
        vectors++;
        if ({ev(), overrun} !== {1'b1, EVT_PRESS, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_mid_pre: got ev=%b ovr=%b want ev=100 ovr=1", ev(), overrun);
        end
        #2;
        rst = 1'b1;
        #1;
        exp_presses = 8'd0;
        vectors++;
        if ({valid, code, overrun, press_count} !== 12'h000) begin
            miscompares++;
            $display("FAIL rst_mid_async: got v=%b c=%0d ovr=%b pc=%0d want all 0", valid, code, overrun, press_count);
        end
        tick();
        rst = 1'b0;
        tick();
        exp_presses = 8'd1;
        vectors++;
        if ({ev(), press_count} !== {1'b1, EVT_PRESS, exp_presses}) begin
            miscompares++;
            $display("FAIL rst_release_press: got ev=%b pc=%0d want ev=100 pc=1", ev(), press_count);
        end
        ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            vectors++;
            if (ev() !== 3'b000) begin
                miscompares++;
                $display("FAIL rst_single_press_t%0d: got %b want 000", k, ev());
            end
        end
        sw = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_presses = 8'd0;
        ready = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            sw = 1'b1;
            tick();
            tick();
            sw = 1'b0;
            tick();
            tick();
            exp_presses = exp_presses + 8'd1;
            if (n == 1 || n == 255 || n == 256) begin
                vectors++;
                if (press_count !== exp_presses) begin
                    miscompares++;
                    $display("FAIL wrap_n%0d: got %0d want %0d", n, press_count, exp_presses);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_hold();
        test_boundary();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
